// File: rtl/seg_refresh_driver.sv
// Multiplexed 4-digit 7-segment refresh driver: prescaled down-counting phase q, registered anodes and segments.
// Optional macro BLANK_EN inserts one dark phase at the start of each digit group to suppress ghosting.
module seg_refresh_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] char_in,
  output logic [3:0] q,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] PRE_LAST = 16'(REFRESH_DIV - 1);

  logic [15:0] pre_q, pre_d;
  logic [3:0]  q_q, q_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        tick;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    s = 7'b1111111;
    case (code)
      4'd0:  s = 7'b1001111;
      4'd1:  s = 7'b1100010;
      4'd2:  s = 7'b0011000;
      4'd3:  s = 7'b1111010;
      4'd4:  s = 7'b1100010;
      4'd5:  s = 7'b1000111;
      4'd6:  s = 7'b0010000;
      4'd7:  s = 7'b1110010;
      4'd8:  s = 7'b1110000;
      4'd10: s = 7'b0000001;
      4'd13: s = 7'b1111110;
      4'd15: s = 7'b0000110;
      default: s = 7'b0010010;
    endcase
    return s;
  endfunction

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? 16'd0 : pre_q + 16'd1;
    q_d   = tick ? q_q - 4'd1 : q_q;
    // q counts down, so each group starts at q[1:0]==0 and runs q, q-1, q-2, q-3
    case (q_q)
      4'd0, 4'd13, 4'd14, 4'd15: an_d = 4'b0111;
      4'd9, 4'd10, 4'd11, 4'd12: an_d = 4'b1011;
      4'd5, 4'd6, 4'd7, 4'd8:    an_d = 4'b1101;
      default:                   an_d = 4'b1110;
    endcase
    seg_d = decode(char_in);
`ifdef BLANK_EN
    if (q_q[1:0] == 2'b00) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= 16'd0;
      q_q   <= 4'b1111;
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      pre_q <= pre_d;
      q_q   <= q_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign q   = q_q;
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_refresh_driver.sv
// Directed bench for seg_refresh_driver at REFRESH_DIV = 4; samples outputs on the falling clock edge.
module tb_seg_refresh_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] char_in = 4'd0;
  logic [3:0] q;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1001111, 7'b1100010, 7'b0011000, 7'b1111010,
    7'b1100010, 7'b1000111, 7'b0010000, 7'b1110010,
    7'b1110000, 7'b0010010, 7'b0000001, 7'b0010010,
    7'b0010010, 7'b1111110, 7'b0010010, 7'b0000110};

  logic [3:0] an_tab [16] = '{
    4'b0111, 4'b1110, 4'b1110, 4'b1110,
    4'b1110, 4'b1101, 4'b1101, 4'b1101,
    4'b1101, 4'b1011, 4'b1011, 4'b1011,
    4'b1011, 4'b0111, 4'b0111, 4'b0111};

`ifdef BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  seg_refresh_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .char_in(char_in),
    .q(q), .an(an), .seg(seg), .dp(dp));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_q(input logic [3:0] target);
    int n = 0;
    while (q !== target && n < 200) begin
      step();
      n++;
    end
    total++;
    if (q !== target) begin
      bad++;
      $display("FAIL wait_q: q=%0d never reached %0d", q, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total += 4;
    if (q !== 4'b1111) begin bad++; $display("FAIL reset_q: got %b want 1111", q); end
    if (an !== 4'b1111) begin bad++; $display("FAIL reset_an: got %b want 1111", an); end
    if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
  endtask

  task automatic test_cadence();
    logic saw_zero;
    saw_zero = 1'b0;
    char_in = 4'd5;
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if (q !== 4'd15) begin bad++; $display("FAIL cadence_hold e%0d: got %0d want 15", e, q); end
      if (e == 1) begin
        total += 2;
        if (an !== 4'b0111) begin bad++; $display("FAIL first_an: got %b want 0111", an); end
        if (seg !== 7'b1000111) begin bad++; $display("FAIL first_seg: got %b want 1000111", seg); end
      end
    end
    step();
    total++;
    if (q !== 4'd14) begin bad++; $display("FAIL cadence_tick1: got %0d want 14", q); end
    for (int t = 0; t < 15; t++) begin
      repeat (4) step();
      if (q === 4'd0) saw_zero = 1'b1;
    end
    total += 2;
    if (q !== 4'd15) begin bad++; $display("FAIL cadence_wrap: got %0d want 15", q); end
    if (saw_zero !== 1'b1) begin bad++; $display("FAIL cadence_zero: q=0 not seen got %b want 1", saw_zero); end
  endtask

  task automatic test_mapping();
    wait_q(4'd14);
    char_in = 4'd2;
    step();
    total += 2;
    if (an !== 4'b0111) begin bad++; $display("FAIL map14_an: got %b want 0111", an); end
    if (seg !== 7'b0011000) begin bad++; $display("FAIL map14_seg: got %b want 0011000", seg); end
    wait_q(4'd6);
    char_in = 4'd13;
    step();
    total += 2;
    if (an !== 4'b1101) begin bad++; $display("FAIL map6_an: got %b want 1101", an); end
    if (seg !== 7'b1111110) begin bad++; $display("FAIL map6_seg: got %b want 1111110", seg); end
  endtask

  task automatic test_blank();
    logic [3:0] ea;
    logic [6:0] es;
    ea = BLANK ? 4'b1111 : 4'b1011;
    es = BLANK ? 7'b1111111 : 7'b1110000;
    wait_q(4'd12);
    char_in = 4'd8;
    step();
    total += 2;
    if (an !== ea) begin bad++; $display("FAIL blank_an: got %b want %b", an, ea); end
    if (seg !== es) begin bad++; $display("FAIL blank_seg: got %b want %b", seg, es); end
  endtask

  task automatic test_decode_sweep();
    for (int c = 0; c < 16; c++) begin
      if (q !== 4'd3) wait_q(4'd3);
      char_in = 4'(c);
      step();
      total += 2;
      if (an !== 4'b1110) begin bad++; $display("FAIL sweep_an c%0d: got %b want 1110", c, an); end
      if (seg !== seg_tab[c]) begin bad++; $display("FAIL sweep_seg c%0d: got %b want %b", c, seg, seg_tab[c]); end
    end
  endtask

  task automatic test_async_reset();
    wait_q(4'd7);
    #2 reset = 1'b1;
    #1;
    total += 4;
    if (q !== 4'd15) begin bad++; $display("FAIL areset_q: got %0d want 15", q); end
    if (an !== 4'b1111) begin bad++; $display("FAIL areset_an: got %b want 1111", an); end
    if (seg !== 7'b1111111) begin bad++; $display("FAIL areset_seg: got %b want 1111111", seg); end
    if (dp !== 1'b1) begin bad++; $display("FAIL areset_dp: got %b want 1", dp); end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if (q !== 4'd15) begin bad++; $display("FAIL areset_hold e%0d: got %0d want 15", e, q); end
    end
    step();
    total++;
    if (q !== 4'd14) begin bad++; $display("FAIL areset_tick: got %0d want 14", q); end
  endtask

  task automatic test_one_hot();
    logic [3:0] pq;
    logic [3:0] ea;
    logic [6:0] es;
    for (int i = 0; i < 256; i++) begin
      pq = q;
      char_in = 4'(i * 7);
      ea = an_tab[pq];
      es = seg_tab[char_in];
      if (BLANK && pq[1:0] == 2'b00) begin
        ea = 4'b1111;
        es = 7'b1111111;
      end
      step();
      total += 4;
      if ($countones(~an) > 1) begin bad++; $display("FAIL onehot i%0d: got an=%b want at most one low", i, an); end
      if (an !== ea) begin bad++; $display("FAIL model_an i%0d q%0d: got %b want %b", i, pq, an, ea); end
      if (seg !== es) begin bad++; $display("FAIL model_seg i%0d: got %b want %b", i, seg, es); end
      if (dp !== 1'b1) begin bad++; $display("FAIL model_dp i%0d: got %b want 1", i, dp); end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_mapping();
    test_blank();
    test_decode_sweep();
    test_async_reset();
    test_one_hot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
